pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It combines the hazard unit's raw hazard, the forwarding unit's ignore-hazard indication, load-in-EXE status, SRAM wait states and taken branches into per-stage freeze, bubble and flush controls. It sits beside the hazard and forwarding units. It owns the only state machine that decides when the pipeline advances, and it bounds SRAM waits with a timeout.

---
 rtl/pipeline_stall_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges hazards, SRAM waits and branches into per-stage pipeline controls.
// Optional stall performance counter is built only when PERF_STALL_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_forwarding,
  input  logic             hazard_raw,
  input  logic             ignore_hazard,
  input  logic             EXE_mem_r_en,
  input  logic             MEM_mem_req,
  input  logic             sram_ready,
  input  logic             branch_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             freeze_mem_wb,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       mem_stall;
  logic       data_stall;

  assign mem_stall  = MEM_mem_req & ~sram_ready;
  // A load-use hazard cannot be forwarded, so it stalls even when forwarding covers it.
  assign data_stall = hazard_raw & (~en_forwarding | ~ignore_hazard | EXE_mem_r_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TMO) begin
            state_q <= TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        TIMEOUT: state_q <= TIMEOUT;
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Mealy decode; everything is forced low while reset is held.
  always_comb begin
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    freeze_mem_wb  = 1'b0;
    bubble_id_exe  = 1'b0;
    flush_if_id    = 1'b0;
    mem_timeout    = 1'b0;
    if (rst) begin
      if (state_q == TIMEOUT || mem_stall) begin
        freeze_pc      = 1'b1;
        freeze_if_id   = 1'b1;
        freeze_id_exe  = 1'b1;
        freeze_exe_mem = 1'b1;
        freeze_mem_wb  = 1'b1;
        mem_timeout    = (state_q == TIMEOUT);
      end else if (branch_taken) begin
        flush_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (data_stall) begin
        freeze_pc     = 1'b1;
        freeze_if_id  = 1'b1;
        bubble_id_exe = 1'b1;
      end
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (freeze_pc && state_q != TIMEOUT && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int MT    = 8;
  localparam int CNT_W = 32;
`ifdef PERF_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk, rst;
  logic en_forwarding, hazard_raw, ignore_hazard, EXE_mem_r_en;
  logic MEM_mem_req, sram_ready, branch_taken;
  logic freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb;
  logic bubble_id_exe, flush_if_id, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0] outs;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .en_forwarding(en_forwarding), .hazard_raw(hazard_raw), .ignore_hazard(ignore_hazard),
    .EXE_mem_r_en(EXE_mem_r_en), .MEM_mem_req(MEM_mem_req), .sram_ready(sram_ready),
    .branch_taken(branch_taken),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .freeze_id_exe(freeze_id_exe),
    .freeze_exe_mem(freeze_exe_mem), .freeze_mem_wb(freeze_mem_wb),
    .bubble_id_exe(bubble_id_exe), .flush_if_id(flush_if_id),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  assign outs = {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, freeze_mem_wb,
                 bubble_id_exe, flush_if_id, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: consecutive stalled cycles seen, sticky timeout, stalled-cycle count.
  int              m_run = 0;
  bit              m_to  = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out(input bit r, input bit ef, input bit hr, input bit ih,
                                           input bit ld, input bit rq, input bit rd, input bit br);
    bit ds;
    ds = hr && (!ef || !ih || ld);
    if (!r)                return 8'b0000_0000;
    if (m_to)              return 8'b1111_1001;
    if (rq && !rd)         return 8'b1111_1000;
    if (br)                return 8'b0000_0110;
    if (ds)                return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  task automatic step(input bit ef, input bit hr, input bit ih, input bit ld,
                      input bit rq, input bit rd, input bit br, input string tag);
    logic [7:0] e;
    @(negedge clk);
    en_forwarding = ef; hazard_raw = hr; ignore_hazard = ih; EXE_mem_r_en = ld;
    MEM_mem_req = rq; sram_ready = rd; branch_taken = br;
    #1;
    e = model_out(1'b1, ef, hr, ih, ld, rq, rd, br);
    chk({tag, "_outs"}, {24'd0, outs}, {24'd0, e});
    chk({tag, "_cnt"}, stall_cycles, CNT_EN ? m_cnt : '0);
    if (!m_to) begin
      if (e[7] && m_cnt != '1) m_cnt = m_cnt + 1;
      if (rq && !rd) begin
        m_run++;
        if (m_run > MT) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Async reset asserted mid-cycle; outputs must drop at once.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_rst_outs"}, {24'd0, outs}, 32'd0);
    chk({tag, "_rst_cnt"}, stall_cycles, 32'd0);
    m_run = 0; m_to = 1'b0; m_cnt = '0;
    @(negedge clk);
    en_forwarding = 0; hazard_raw = 0; ignore_hazard = 0; EXE_mem_r_en = 0;
    MEM_mem_req = 0; sram_ready = 0; branch_taken = 0;
    rst = 1'b1;
  endtask

  initial begin
    bit slow;
    rst = 1'b0;
    en_forwarding = 0; hazard_raw = 0; ignore_hazard = 0; EXE_mem_r_en = 0;
    MEM_mem_req = 1; sram_ready = 0; branch_taken = 1;
    #1;
    chk("reset_outs", {24'd0, outs}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    @(negedge clk);
    MEM_mem_req = 0; branch_taken = 0;
    rst = 1'b1;

    // Load-use, forwarded hazard, forwarding disabled
    step(1, 1, 1, 1, 0, 0, 0, "load_use");
    idle("after_load_use");
    step(1, 1, 1, 0, 0, 0, 0, "fwd_hazard");
    step(0, 1, 1, 0, 0, 0, 0, "no_fwd");
    step(1, 1, 0, 0, 0, 0, 0, "not_covered");

    // SRAM wait of 3 cycles
    repeat (3) step(0, 0, 0, 0, 1, 0, 0, "sram_wait");
    step(0, 0, 0, 0, 1, 1, 0, "sram_ready");
    idle("after_sram");

    // Branch held across a 2-cycle memory freeze, also with a data hazard present
    repeat (2) step(0, 1, 0, 0, 1, 0, 1, "br_in_wait");
    step(0, 1, 0, 0, 1, 1, 1, "br_release");
    // Request dropped while waiting counts as ready
    step(0, 0, 0, 0, 1, 0, 0, "drop_wait");
    step(0, 0, 0, 0, 0, 0, 0, "drop_req");

    // Timeout, then branches and ready must be ignored
    repeat (MT + 1) step(0, 0, 0, 0, 1, 0, 0, "to_wait");
    step(0, 0, 0, 0, 1, 0, 1, "to_first");
    step(0, 1, 0, 0, 0, 1, 1, "to_sticky");
    idle("to_idle");
    async_reset("to");
    idle("post_to_reset");

    // Reset in the middle of a memory wait
    repeat (3) step(0, 0, 0, 0, 1, 0, 0, "mid_wait");
    async_reset("mid_wait");
    idle("post_mid_reset");
    step(0, 0, 0, 0, 1, 0, 0, "post_reset_wait");
    step(0, 0, 0, 0, 1, 1, 0, "post_reset_ready");

    // Randomized blocks; some favour long SRAM waits to reach the timeout
    for (int blk = 0; blk < 40; blk++) begin
      slow = ($urandom % 4) == 0;
      for (int c = 0; c < 20; c++) begin
        step($urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 3) == 0,
             ($urandom % 2) == 0 || slow,
             slow ? (($urandom % 10) == 0) : (($urandom % 3) != 0),
             ($urandom % 4) == 0, "rand");
        if (($urandom % 64) == 0) async_reset("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
